alu_dispatch: RTL and testbench

//  Upstream issue stage for the ALU: accepts register-addressed instructions, reads operands

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_regfile.sv | 52 +++++
 rtl/alu_dispatch.sv | 179 +++++++++++++++++
 tb/tb_alu_dispatch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch stage: FSM state encoding and opcode width.
package alu_pkg;

  localparam int OPCODE_W = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT      = 2'd2,
    WRITEBACK = 2'd3
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: three combinational read ports, one synchronous write port.
// Register 0 is hardwired to zero; writes addressed to it are dropped.
module alu_regfile #(
  parameter  int N    = 4,
  parameter  int REGS = 8,
  localparam int AW   = $clog2(REGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  input  logic [AW-1:0] raddr_o_i,
  output logic [N-1:0]  rdata_a_o,
  output logic [N-1:0]  rdata_b_o,
  output logic [N-1:0]  rdata_o_o
);

  logic [N-1:0] regs_q [REGS];

  // Read helper that forces register 0 to zero regardless of storage contents.
  function automatic logic [N-1:0] read_reg(input logic [AW-1:0] addr);
    logic [N-1:0] val;
    if (addr == {AW{1'b0}}) begin
      val = {N{1'b0}};
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  // Storage update: clear everything on reset, otherwise single write port skipping register 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= {N{1'b0}};
      end
    end else if (we_i && (waddr_i != {AW{1'b0}})) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read ports for operand A, operand B and the observation port.
  always_comb begin
    rdata_a_o = read_reg(raddr_a_i);
    rdata_b_o = read_reg(raddr_b_i);
    rdata_o_o = read_reg(raddr_o_i);
  end

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage for the ALU: reads operands from the register file, pulses alu_start,
// waits (bounded) for alu_finished and writes the result back. One operation in flight.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int REGS    = 8,
  parameter  int TIMEOUT = 255,
  localparam int AW      = $clog2(REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] instr_opcode,
  input  logic [AW-1:0]       instr_rd,
  input  logic [AW-1:0]       instr_rs1,
  input  logic [AW-1:0]       instr_rs2,
  input  logic                load_en,
  input  logic [AW-1:0]       load_addr,
  input  logic [N-1:0]        load_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [N-1:0]        rd_data,
  output logic                alu_start,
  input  logic                alu_finished,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic [N-1:0]        alu_A,
  output logic [N-1:0]        alu_B,
  input  logic [N-1:0]        alu_Y,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [N-1:0]        a_q, a_d;
  logic [N-1:0]        b_q, b_d;
  logic [N-1:0]        y_q, y_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                we_s;
  logic [AW-1:0]       waddr_s;
  logic [N-1:0]        wdata_s;
  logic [N-1:0]        rs1_data_s;
  logic [N-1:0]        rs2_data_s;

  alu_regfile #(
    .N    (N),
    .REGS (REGS)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .we_i      (we_s),
    .waddr_i   (waddr_s),
    .wdata_i   (wdata_s),
    .raddr_a_i (instr_rs1),
    .raddr_b_i (instr_rs2),
    .raddr_o_i (rd_addr),
    .rdata_a_o (rs1_data_s),
    .rdata_b_o (rs2_data_s),
    .rdata_o_o (rd_data)
  );

  // Write-port mux: writeback has the port in WRITEBACK, preloads are honoured only in IDLE.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = load_addr;
    wdata_s = load_data;
    if (state_q == WRITEBACK) begin
      we_s    = 1'b1;
      waddr_s = rd_q;
      wdata_s = y_q;
    end else if (state_q == IDLE) begin
      we_s    = load_en;
    end else begin
      we_s    = 1'b0;
    end
  end

  // Next-state and datapath-register logic for the dispatch FSM.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          // Operands come from the pre-edge register contents, so a same-cycle load is not seen.
          opcode_d = instr_opcode;
          rd_d     = instr_rd;
          a_d      = rs1_data_s;
          b_d      = rs2_data_s;
          start_d  = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = {CW{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_finished) begin
          y_d     = alu_Y;
          done_d  = 1'b1;
          state_d = WRITEBACK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Give up on the ALU: flag it permanently and drop the result.
          error_d = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      WRITEBACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      opcode_q <= {OPCODE_W{1'b0}};
      rd_q     <= {AW{1'b0}};
      a_q      <= {N{1'b0}};
      b_q      <= {N{1'b0}};
      y_q      <= {N{1'b0}};
      cnt_q    <= {CW{1'b0}};
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Output mapping: handshake and status derived from registered state.
  always_comb begin
    instr_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    alu_start   = start_q;
    alu_opcode  = opcode_q;
    alu_A       = a_q;
    alu_B       = b_q;
    done        = done_q;
    error       = error_q;
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a stub ALU (Y = A + B mod 16, finished k cycles after start).
module tb_alu_dispatch;

  localparam int N       = 4;
  localparam int REGS    = 8;
  localparam int TIMEOUT = 4;
  localparam int AW      = 3;

  logic          clock;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [4:0]    instr_opcode;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [N-1:0]  load_data;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          alu_start;
  logic          alu_finished;
  logic [4:0]    alu_opcode;
  logic [N-1:0]  alu_A, alu_B, alu_Y;
  logic          busy, done, error;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int starts    = 0;
  int dones     = 0;
  int stub_k    = 1;
  logic [7:0] stub_cd;
  logic fin_force = 1'b0;

  alu_dispatch #(.N(N), .REGS(REGS), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_start(alu_start), .alu_finished(alu_finished), .alu_opcode(alu_opcode),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Y(alu_Y),
    .busy(busy), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stub ALU: countdown loaded with k on the start pulse; finished while it reads 1 (k=0 never finishes).
  assign alu_Y        = alu_A + alu_B;
  assign alu_finished = (stub_cd == 8'd1) || fin_force;
  always @(posedge clock) begin
    if (reset) stub_cd <= 8'd0;
    else if (alu_start) stub_cd <= 8'(stub_k);
    else if (stub_cd != 8'd0) stub_cd <= stub_cd - 8'd1;
  end

  // Event monitors for start pulses and done pulses.
  always @(posedge clock) begin
    if (alu_start) starts <= starts + 1;
    if (done) dones <= dones + 1;
  end

  typedef struct {
    logic [AW-1:0] ra; logic [N-1:0] va;
    logic [AW-1:0] rb; logic [N-1:0] vb;
    logic [AW-1:0] rd; int k; logic [N-1:0] exp;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [N-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [N-1:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  // Issue one instruction from IDLE and record cycle offsets (relative to the accept edge).
  task automatic run_op(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input int k, output int done_cyc, output int ready_cyc,
                        output logic [N-1:0] a_seen, output logic [N-1:0] b_seen, output logic st1);
    stub_k = k;
    instr_valid = 1'b1; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_opcode = 5'h0A;
    cyc();
    instr_valid = 1'b0;
    st1 = alu_start && !instr_ready;
    a_seen = alu_A; b_seen = alu_B;
    done_cyc = -1; ready_cyc = -1;
    for (int i = 2; i <= 14; i++) begin
      cyc();
      if (done && done_cyc < 0) done_cyc = i;
      if (instr_ready && ready_cyc < 0) begin
        ready_cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!instr_ready && n < 20) begin cyc(); n++; end
    check({name, "_idle"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    int dc, rc, s0, d0, seen;
    logic [N-1:0] av, bv, rv;
    logic st;

    vecs[0] = '{ra:3'd1, va:4'd3,  rb:3'd2, vb:4'd5, rd:3'd3, k:3, exp:4'd8};
    vecs[1] = '{ra:3'd1, va:4'd9,  rb:3'd2, vb:4'd9, rd:3'd4, k:1, exp:4'd2};
    vecs[2] = '{ra:3'd6, va:4'd15, rb:3'd7, vb:4'd1, rd:3'd5, k:2, exp:4'd0};
    vecs[3] = '{ra:3'd1, va:4'd7,  rb:3'd1, vb:4'd7, rd:3'd1, k:1, exp:4'd14};
    vecs[4] = '{ra:3'd2, va:4'd4,  rb:3'd3, vb:4'd4, rd:3'd0, k:2, exp:4'd0};

    reset = 1'b1; instr_valid = 1'b0; instr_opcode = 5'd0; instr_rd = 3'd0;
    instr_rs1 = 3'd0; instr_rs2 = 3'd0; load_en = 1'b0; load_addr = 3'd0;
    load_data = 4'd0; rd_addr = 3'd0;
    cyc(); cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    check("rst_start", 32'(alu_start), 32'd0);
    check("rst_A", 32'(alu_A), 32'd0);
    reset = 1'b0;
    cyc();

    // Table-driven main function: preload, issue, check handshake timing and result.
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].ra, vecs[v].va);
      load(vecs[v].rb, vecs[v].vb);
      s0 = starts; d0 = dones;
      run_op(vecs[v].rd, vecs[v].ra, vecs[v].rb, vecs[v].k, dc, rc, av, bv, st);
      check($sformatf("v%0d_start", v), 32'(st), 32'd1);
      check($sformatf("v%0d_A", v), 32'(av), 32'(vecs[v].va));
      check($sformatf("v%0d_B", v), 32'(bv), 32'(vecs[v].vb));
      check($sformatf("v%0d_done_cyc", v), 32'(dc), 32'(2 + vecs[v].k));
      check($sformatf("v%0d_ready_cyc", v), 32'(rc), 32'(3 + vecs[v].k));
      check($sformatf("v%0d_nstart", v), 32'(starts - s0), 32'd1);
      check($sformatf("v%0d_ndone", v), 32'(dones - d0), 32'd1);
      peek(vecs[v].rd, rv);
      check($sformatf("v%0d_result", v), 32'(rv), 32'(vecs[v].exp));
    end
    // r1=14 r2=4 r3=4 r4=2 r5=0 r6=15 r7=1

    // Load during WAIT must be ignored.
    stub_k = 3;
    instr_valid = 1'b1; instr_rd = 3'd7; instr_rs1 = 3'd4; instr_rs2 = 3'd4;
    cyc(); instr_valid = 1'b0;
    cyc();
    load(3'd5, 4'd10);
    wait_idle("ldwait");
    peek(3'd5, rv); check("ldwait_r5", 32'(rv), 32'd0);
    peek(3'd7, rv); check("ldwait_r7", 32'(rv), 32'd4);

    // Load and accept in the same IDLE cycle: operands see the old value, load still lands.
    stub_k = 1;
    instr_valid = 1'b1; instr_rd = 3'd2; instr_rs1 = 3'd6; instr_rs2 = 3'd6; instr_opcode = 5'h13;
    load_en = 1'b1; load_addr = 3'd6; load_data = 4'd3;
    cyc(); instr_valid = 1'b0; load_en = 1'b0;
    check("same_A", 32'(alu_A), 32'd15);
    check("same_op", 32'(alu_opcode), 32'h13);
    wait_idle("same");
    peek(3'd2, rv); check("same_r2", 32'(rv), 32'd14);
    peek(3'd6, rv); check("same_r6", 32'(rv), 32'd3);

    // Timeout: stub never finishes; abort after TIMEOUT wait cycles.
    d0 = dones;
    stub_k = 0;
    instr_valid = 1'b1; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd1;
    cyc(); instr_valid = 1'b0;              // t+1
    cyc(); cyc(); cyc(); cyc();             // t+5, last WAIT cycle
    check("to_err_early", 32'(error), 32'd0);
    check("to_busy_early", 32'(busy), 32'd1);
    cyc();                                  // t+6
    check("to_err", 32'(error), 32'd1);
    check("to_ready", 32'(instr_ready), 32'd1);
    check("to_ndone", 32'(dones - d0), 32'd0);
    peek(3'd3, rv); check("to_r3", 32'(rv), 32'd4);
    run_op(3'd4, 3'd2, 3'd2, 1, dc, rc, av, bv, st);
    peek(3'd4, rv); check("to_next_r4", 32'(rv), 32'd12);
    check("to_sticky", 32'(error), 32'd1);

    // Reset while in WAIT, then a late finished must be ignored.
    stub_k = 0;
    instr_valid = 1'b1; instr_rd = 3'd5; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    cyc(); instr_valid = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_err", 32'(error), 32'd0);
    check("rw_A", 32'(alu_A), 32'd0);
    peek(3'd1, rv); check("rw_r1", 32'(rv), 32'd0);
    peek(3'd2, rv); check("rw_r2", 32'(rv), 32'd0);
    reset = 1'b0;
    d0 = dones;
    fin_force = 1'b1;
    cyc();
    fin_force = 1'b0;
    check("rw_late_busy", 32'(busy), 32'd0);
    cyc();
    check("rw_late_done", 32'(dones - d0), 32'd0);

    // Back-to-back: valid held high, r1 = r1 + r1 twice from 1.
    load(3'd1, 4'd1);
    s0 = starts; seen = 0; stub_k = 1;
    instr_valid = 1'b1; instr_rd = 3'd1; instr_rs1 = 3'd1; instr_rs2 = 3'd1;
    for (int i = 0; i < 30 && seen < 2; i++) begin
      cyc();
      if (alu_start) seen++;
    end
    instr_valid = 1'b0;
    check("b2b_seen", 32'(seen), 32'd2);
    wait_idle("b2b");
    cyc(); cyc();
    peek(3'd1, rv); check("b2b_r1", 32'(rv), 32'd4);
    check("b2b_nstart", 32'(starts - s0), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
